// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider: default counter
// width and common half-period values for a 100 MHz board clock.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF  = 27;
  localparam int unsigned HALF_1HZ   = 50_000_000;
  localparam int unsigned HALF_100HZ = 500_000;
  localparam int unsigned HALF_1KHZ  = 50_000;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active/pending divide values,
// registered 50%-duty clock, rising-edge tick and pending flag.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = HALF_1HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] wr_half,
  output logic             div_clk,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_half;
  logic [CNT_W-1:0] pend_half;
  logic [CNT_W-1:0] wr_val;
  logic             wrap;
  logic             boundary;

  always_comb begin
    wr_val   = (wr_half == '0) ? CNT_W'(1) : wr_half;
    wrap     = (cnt == act_half - CNT_W'(1));
    boundary = wrap && div_clk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div_clk   <= 1'b0;
      tick      <= 1'b0;
      pend      <= 1'b0;
      act_half  <= CNT_W'(DEFAULT_HALF);
      pend_half <= CNT_W'(DEFAULT_HALF);
    end else if (!en) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      // A fresh write wins over an older pending value.
      if (we)
        act_half <= wr_val;
      else if (pend)
        act_half <= pend_half;
    end else begin
      cnt     <= wrap ? '0 : cnt + CNT_W'(1);
      div_clk <= wrap ? ~div_clk : div_clk;
      tick    <= wrap && !div_clk;
      if (we) begin
        if (boundary) begin
          act_half <= wr_val;
          pend     <= 1'b0;
        end else begin
          pend_half <= wr_val;
          pend      <= 1'b1;
        end
      end else if (boundary && pend) begin
        act_half <= pend_half;
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator: write-address
// decode and per-channel instantiation.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = HALF_1HZ,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend
);

  logic [NUM_CH-1:0] ch_we;

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_we[g] = cfg_we && (cfg_ch == CH_W'(g));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .we      (ch_we[g]),
      .wr_half (cfg_half),
      .div_clk (div_clk[g]),
      .tick    (tick[g]),
      .pend    (cfg_pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a period-position reference model
// predicts outputs per edge; a negedge monitor pops and compares.
module tb_clk_div_multi;

  localparam int unsigned NCH   = 3;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEFH  = 4;
  localparam int unsigned CHW   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_half = '0;
  logic [NCH-1:0] div_clk, tick, cfg_pend;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH       (NCH),
    .CNT_W        (CW),
    .DEFAULT_HALF (DEFH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .div_clk  (div_clk),
    .tick     (tick),
    .cfg_pend (cfg_pend)
  );

  typedef struct packed {
    logic [NCH-1:0] d;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t exp_next;
  int total = 0;
  int bad = 0;

  // Model state: half, pending half, pending flag and edges elapsed in the
  // current output period (0..2*half-1). High phase is elapsed >= half.
  int unsigned m_h[NCH];
  int unsigned m_p[NCH];
  int unsigned m_e[NCH];
  bit          m_pend[NCH];

  function automatic void model_edge();
    for (int i = 0; i < NCH; i++) begin
      bit wr;
      bit bnd;
      int unsigned wv;
      wr = cfg_we && (int'(cfg_ch) == i);
      wv = (cfg_half == 0) ? 1 : int'(cfg_half);
      if (rst) begin
        m_h[i] = DEFH; m_p[i] = DEFH; m_e[i] = 0; m_pend[i] = 0;
      end else if (!en[i]) begin
        if (m_pend[i]) m_h[i] = m_p[i];
        if (wr) m_h[i] = wv;
        m_pend[i] = 0;
        m_e[i] = 0;
      end else begin
        bnd = (m_e[i] == 2 * m_h[i] - 1);
        m_e[i] = bnd ? 0 : m_e[i] + 1;
        if (wr) begin
          if (bnd) begin m_h[i] = wv; m_pend[i] = 0; end
          else begin m_p[i] = wv; m_pend[i] = 1; end
        end else if (bnd && m_pend[i]) begin
          m_h[i] = m_p[i]; m_pend[i] = 0;
        end
      end
      exp_next.d[i] = !rst && en[i] && (m_e[i] >= m_h[i]);
      exp_next.t[i] = !rst && en[i] && (m_e[i] == m_h[i]);
      exp_next.p[i] = m_pend[i];
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    sb.push_back(exp_next);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until channel ch sits at the given elapsed count before an edge.
  task automatic wait_pos(input int ch, input int unsigned pos);
    int k;
    k = 0;
    while (m_e[ch] != pos && k < 200) begin
      step();
      k++;
    end
    if (m_e[ch] != pos) begin
      total++; bad++;
      $display("FAIL wait_pos ch=%0d got=%0d want=%0d", ch, m_e[ch], pos);
    end
  endtask

  task automatic write(input int ch, input int unsigned h);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_half = CW'(h);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("div_clk", div_clk, e.d);
        cmp("tick", tick, e.t);
        cmp("cfg_pend", cfg_pend, e.p);
      end
    end
  end

  initial begin
    run(3);
    rst = 1'b0;
    en = '1;
    run(24);
    // Rewrite ch0 one cycle into its high phase: pending until boundary.
    wait_pos(0, m_h[0] + 1);
    write(0, 2);
    run(20);
    // Write exactly on the boundary edge: applies with no pending flag.
    wait_pos(0, 2 * m_h[0] - 1);
    write(0, 3);
    run(16);
    write(0, 0);
    run(8);
    // Disable ch1 while a value is pending, then re-enable.
    wait_pos(1, 1);
    write(1, 5);
    en[1] = 1'b0;
    run(2);
    en[1] = 1'b1;
    run(24);
    // Out-of-range channel and cross-channel writes.
    write(3, 1);
    write(2, 6);
    run(30);
    // Reset mid-phase together with a write.
    wait_pos(2, 3);
    rst = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd2;
    step();
    rst = 1'b0; cfg_we = 1'b0;
    run(20);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_ch = CHW'($urandom_range(0, 3));
      cfg_half = CW'($urandom_range(0, 6));
      step();
    end
    rst = 1'b0; cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
